// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution layer sequencer.
package conv_seq_pkg;

   localparam int unsigned NUM_TARGETS_DEF = 5;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StArm     = 3'd1,
      StLoad    = 3'd2,
      StCompute = 3'd3,
      StDone    = 3'd4,
      StErr     = 3'd5
   } seq_state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_SHORT   = 2'b01;
   localparam logic [1:0] ERR_LONG    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// 64-bit AXI-Stream weight channel used on both sides of the sequencer.
interface conv_layer_sequencer_if;

   logic        tvalid;
   logic        tready;
   logic [63:0] tdata;
   logic        tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/seq_timeout_ctr.sv
// Saturating COMPUTE-cycle counter; flags the cycle in which the count reaches the limit.
module seq_timeout_ctr #(
   parameter int unsigned TMO_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [TMO_W-1:0] limit,
   output logic             expired
);

   logic [TMO_W-1:0] cnt_q;
   logic [TMO_W:0]   cnt_inc;

   assign cnt_inc = {1'b0, cnt_q} + (TMO_W + 1)'(1);
   // This enabled cycle is number cnt_q+1.
   assign expired = en && (cnt_inc >= {1'b0, limit});

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_q <= cnt_inc[TMO_W-1:0];
      end
   end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Weight-load / compute sequencer for the conv accelerator.
// Optional COMPUTE timeout enabled by defining SEQ_TIMEOUT_EN.
module conv_layer_sequencer
   import conv_seq_pkg::*;
#(
   parameter int unsigned NUM_TARGETS = NUM_TARGETS_DEF,
   parameter int unsigned BEAT_W      = 16,
   parameter int unsigned TMO_W       = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_cmd_start,
   input  logic                   i_cmd_abort,
   input  logic [BEAT_W-1:0]      i_cfg_beats,
   input  logic [TMO_W-1:0]       i_cfg_timeout,
   conv_layer_sequencer_if.slave  s_axis_w,
   conv_layer_sequencer_if.master m_axis_w,
   output logic                   o_load_weights,
   output logic [3:0]             o_target_layer,
   output logic                   o_start_compute,
   input  logic                   i_compute_done,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_error,
   output logic [1:0]             o_err_code,
   output logic [2:0]             o_state
);

   seq_state_e        state_q, state_d;
   logic [3:0]        k_q, k_d;
   logic [BEAT_W-1:0] cnt_q, cnt_d;
   logic [1:0]        err_q, err_d;
   logic [BEAT_W:0]   cnt_inc;
   logic              hs;
   logic              timeout;

   assign hs      = (state_q == StLoad) && s_axis_w.tvalid && m_axis_w.tready;
   assign cnt_inc = {1'b0, cnt_q} + (BEAT_W + 1)'(1);

`ifdef SEQ_TIMEOUT_EN
   seq_timeout_ctr #(
      .TMO_W (TMO_W)
   ) u_timeout_ctr (
      .clk     (clk),
      .rst     (rst),
      .clr     (i_cmd_abort || (state_q != StCompute)),
      .en      (state_q == StCompute),
      .limit   (i_cfg_timeout),
      .expired (timeout)
   );
`else
   logic unused_cfg_timeout;
   assign unused_cfg_timeout = ^i_cfg_timeout;
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         k_q     <= '0;
         cnt_q   <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (i_cmd_abort) begin
         state_d = StIdle;
         k_d     = '0;
         cnt_d   = '0;
         err_d   = ERR_NONE;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_cmd_start && (i_cfg_beats != '0)) begin
                  state_d = StArm;
                  k_d     = '0;
                  cnt_d   = '0;
               end
            end
            StArm: state_d = StLoad;
            StLoad: begin
               if (hs) begin
                  // Frame length is judged against the live cfg on every accepted beat.
                  if (s_axis_w.tlast) begin
                     if (cnt_inc == {1'b0, i_cfg_beats}) begin
                        cnt_d = '0;
                        if (k_q == 4'(NUM_TARGETS - 1)) begin
                           state_d = StCompute;
                        end else begin
                           state_d = StArm;
                           k_d     = k_q + 4'd1;
                        end
                     end else begin
                        state_d = StErr;
                        err_d   = (cnt_inc < {1'b0, i_cfg_beats}) ? ERR_SHORT : ERR_LONG;
                     end
                  end else if (cnt_inc >= {1'b0, i_cfg_beats}) begin
                     state_d = StErr;
                     err_d   = ERR_LONG;
                  end else begin
                     cnt_d = cnt_inc[BEAT_W-1:0];
                  end
               end
            end
            StCompute: begin
               if (i_compute_done) begin
                  state_d = StDone;
               end else if (timeout) begin
                  state_d = StErr;
                  err_d   = ERR_TIMEOUT;
               end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StErr;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      m_axis_w.tvalid = (state_q == StLoad) && s_axis_w.tvalid;
      s_axis_w.tready = (state_q == StLoad) && m_axis_w.tready;
      m_axis_w.tdata  = s_axis_w.tdata;
      m_axis_w.tlast  = s_axis_w.tlast;
      o_load_weights  = (state_q == StArm);
      o_target_layer  = ((state_q == StArm) || (state_q == StLoad)) ? k_q : 4'd0;
      o_start_compute = (state_q == StCompute);
      o_busy          = (state_q == StArm) || (state_q == StLoad) || (state_q == StCompute);
      o_done          = (state_q == StDone);
      o_error         = (state_q == StErr);
      o_err_code      = err_q;
      o_state         = state_q;
   end

endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_TARGETS, default 5, meaning weight targets loaded per run (L1 cores 0..3, L2 = 4).
REQ-002 SHALL have parameter BEAT_W, default 16, meaning width of the per-target beat counter.
REQ-003 SHALL have parameter TMO_W, default 24, meaning width of the compute timeout counter.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-005 SHALL have i_cmd_start (input, 1): pulse that starts a run, sampled in IDLE only.
REQ-006 SHALL have i_cmd_abort (input, 1): return to IDLE from any state.
REQ-007 SHALL have i_cfg_beats (input, BEAT_W): expected weight beats per target; 0 is illegal and leaves the block in IDLE.
REQ-008 SHALL have i_cfg_timeout (input, TMO_W): maximum number of COMPUTE cycles.
REQ-009 SHALL have s_axis_w_tvalid, s_axis_w_tready, s_axis_w_tdata[63:0], s_axis_w_tlast: the host weight stream (slave side).
REQ-010 SHALL have m_axis_w_tvalid, m_axis_w_tready, m_axis_w_tdata[63:0], m_axis_w_tlast: the weight stream forwarded to the accelerator (master side).
REQ-011 SHALL have the accelerator control outputs o_load_weights (1), o_target_layer (4) and o_start_compute (1), and the input i_compute_done (1).
REQ-012 SHALL have the status outputs o_busy (1), o_done (1), o_error (1), o_err_code (2) and o_state (3).

Function
REQ-013 SHALL implement states IDLE, ARM, LOAD, COMPUTE, DONE and ERR.
REQ-014 IDLE: on i_cmd_start with i_cfg_beats != 0, SHALL set target k = 0, clear the beat count and go to ARM.
REQ-015 ARM: SHALL drive o_load_weights = 1 for exactly one cycle with o_target_layer = k, then go to LOAD.
REQ-016 LOAD: SHALL pass the stream combinationally (m_tvalid = s_tvalid, s_tready = m_tready, data/last unchanged); beats count only on an m_tvalid && m_tready handshake.
REQ-017 Outside LOAD: s_axis_w_tready = 0 and m_axis_w_tvalid = 0.
REQ-018 LOAD end: on a handshake where tlast = 1 and count+1 == i_cfg_beats, SHALL go to ARM with k+1 if k < NUM_TARGETS-1, else to COMPUTE.
REQ-019 Short frame (tlast with count+1 < cfg): SHALL go to ERR with code 01; long frame (count+1 == cfg without tlast): SHALL go to ERR with code 10.
REQ-020 COMPUTE: SHALL hold o_start_compute = 1 (level) and o_target_layer = 0, and increment the timeout counter each cycle.
REQ-021 COMPUTE: on i_compute_done, SHALL go to DONE; done takes priority over timeout in the same cycle.
REQ-022 DONE: SHALL assert o_done for one cycle, then go to IDLE.
REQ-023 ERR: SHALL hold o_error = 1 and o_err_code until i_cmd_abort; i_cmd_start is ignored in ERR.
REQ-024 i_cmd_abort SHALL have highest priority: it takes effect on the next edge from any state, clears counters and k, and discards any beat in flight after the abort edge.
REQ-025 o_busy = 1 in ARM, LOAD and COMPUTE; o_state SHALL carry the state encoding.
REQ-026 Counters SHALL NOT wrap: the beat count saturates by the REQ-019 rule, and the timeout counter stops at its terminal value.

Reset
REQ-027 On rst: state = IDLE, k = 0, counters = 0, o_err_code = 00, and all outputs = 0 (stream gated per REQ-017).
REQ-028 rst asserted mid-LOAD SHALL drop the transfer with no further handshakes; the host must resend from target 0.

Configuration
REQ-029 With macro SEQ_TIMEOUT_EN defined: when the COMPUTE cycle count reaches i_cfg_timeout without done, SHALL go to ERR with code 11.
REQ-030 Without SEQ_TIMEOUT_EN: no timeout counter; COMPUTE waits indefinitely and code 11 is never produced.

Structure
REQ-031 A shared package conv_seq_pkg SHALL hold the state enumeration, the error-code constants (00 none, 01 short, 10 long, 11 timeout) and NUM_TARGETS_DEF.
REQ-032 The timeout counter SHALL be the sub-module seq_timeout_ctr, instantiated only under SEQ_TIMEOUT_EN; the rest is a single FSM.

Verification
REQ-033 Nominal: cfg_beats = 4, five clean 4-beat frames, done asserted 100 cycles into COMPUTE -> five o_load_weights pulses with targets 0..4, 20 forwarded beats, o_start_compute high for 100 cycles, one o_done pulse.
REQ-034 Backpressure: m_tready toggling 1/0 every cycle during LOAD -> no beat lost or duplicated, count = 4 per target, s_tready mirrors m_tready.
REQ-035 Short frame: tlast on beat 3 with cfg 4 for target 2 -> ERR with code 01, targets 3..4 not armed, stream gated.
REQ-036 Timeout (SEQ_TIMEOUT_EN): cfg_timeout = 50, no done -> ERR with code 11 at COMPUTE cycle 50; without the macro -> still in COMPUTE at cycle 1000.
REQ-037 Abort/reset: i_cmd_abort mid-LOAD at target 1 beat 2 -> IDLE next cycle, o_busy = 0, restart runs from target 0; same scenario with rst -> identical outcome.
